// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad responder: answers scanner row drive on the columns,
// emulating press bounce, hold, release bounce and a post-release gap.
module keypad_emulator #(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter int unsigned BOUNCE_TOGGLE = 4,
  parameter int unsigned GAP_CYCLES    = 8,
  parameter int unsigned HOLD_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        line,
  output logic [3:0]        col,
  input  logic              req_valid,
  input  logic [3:0]        req_key,
  input  logic [HOLD_W-1:0] hold_len,
  output logic              req_ready,
  output logic              busy,
  output logic              contact,
  output logic              done
);

  localparam int unsigned HMAX = (1 << HOLD_W) - 1;
  localparam int unsigned M1 =
    (BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES;
  localparam int unsigned MAXC = (M1 > HMAX) ? M1 : HMAX;
  localparam int unsigned CW =
    (MAXC > 0) ? $clog2(MAXC + 1) : 1;
  localparam int unsigned TW =
    (BOUNCE_TOGGLE > 1) ? $clog2(BOUNCE_TOGGLE) : 1;

  localparam logic [CW-1:0] BLAST =
    (BOUNCE_CYCLES == 0) ? '0 : CW'(BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] GLAST =
    (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(BOUNCE_TOGGLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_IN,
    S_HELD,
    S_BOUNCE_OUT,
    S_GAP
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_tcnt;
  logic              r_contact;
  logic              r_done;
  logic [3:0]        r_key;
  logic [HOLD_W-1:0] r_hold;

  logic [CW-1:0]     w_hold_last;
  logic [3:0]        w_col;
  logic [1:0]        w_row;
  logic [1:0]        w_cidx;

  assign w_hold_last = CW'(r_hold - HOLD_W'(1));
  assign w_row       = r_key[3:2];
  assign w_cidx      = r_key[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_contact <= 1'b0;
      r_done    <= 1'b0;
      r_key     <= '0;
      r_hold    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_contact <= 1'b0;
          if (req_valid) begin
            r_key     <= req_key;
            r_hold    <= (hold_len == '0) ?
                         HOLD_W'(1) : hold_len;
            r_cnt     <= '0;
            r_tcnt    <= '0;
            r_contact <= 1'b1;
            r_state   <= S_BOUNCE_IN;
          end
        end
        S_BOUNCE_IN: begin
          if (r_cnt == BLAST) begin
            r_cnt     <= '0;
            r_tcnt    <= '0;
            r_contact <= 1'b1;
            r_state   <= S_HELD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (r_tcnt == TLAST) begin
              r_tcnt    <= '0;
              r_contact <= ~r_contact;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
        end
        S_HELD: begin
          if (r_cnt == w_hold_last) begin
            r_cnt     <= '0;
            r_tcnt    <= '0;
            r_contact <= 1'b0;
            r_state   <= S_BOUNCE_OUT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_BOUNCE_OUT: begin
          if (r_cnt == BLAST) begin
            r_cnt     <= '0;
            r_tcnt    <= '0;
            r_contact <= 1'b0;
            r_state   <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (r_tcnt == TLAST) begin
              r_tcnt    <= '0;
              r_contact <= ~r_contact;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
        end
        S_GAP: begin
          r_contact <= 1'b0;
          if (r_cnt == GLAST) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_contact <= 1'b0;
        end
      endcase
    end
  end

  // Only the latched key's row/column pair is ever shorted.
  always_comb begin
    w_col = 4'b1111;
    if (r_contact && !line[w_row])
      w_col[w_cidx] = 1'b0;
  end

  assign col       = w_col;
  assign contact   = r_contact;
  assign done      = r_done;
  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: reset, press timing,
// bounce pattern, ignored requests, key table and mid-press reset.
module tb_keypad_emulator;

  logic        clk;
  logic        rst;
  logic [3:0]  line;
  logic [3:0]  col;
  logic        req_valid;
  logic [3:0]  req_key;
  logic [15:0] hold_len;
  logic        req_ready;
  logic        busy;
  logic        contact;
  logic        done;

  int checks;
  int failures;

  keypad_emulator dut (
    .clk       (clk),
    .rst       (rst),
    .line      (line),
    .col       (col),
    .req_valid (req_valid),
    .req_key   (req_key),
    .hold_len  (hold_len),
    .req_ready (req_ready),
    .busy      (busy),
    .contact   (contact),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  key;
    logic [15:0] hold;
    logic [3:0]  ln;
    logic [3:0]  exp_col;
    int          exp_busy;
  } vec_t;

  vec_t vt[7];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic exp_con(int k, int h);
    if (k < 16)      return ((k / 4) % 2) == 0;
    if (k < 16 + h)  return 1'b1;
    if (k < 32 + h)  return (((k - 16 - h) / 4) % 2) == 1;
    return 1'b0;
  endfunction

  // Issue one request, run it to completion with a static line.
  task automatic press(vec_t v, int idx);
    int h;
    int bcnt;
    int dcnt;
    int cbad;
    logic [3:0] ec;
    h = (v.hold == 0) ? 1 : int'(v.hold);
    bcnt = 0;
    dcnt = 0;
    cbad = 0;
    line      = v.ln;
    req_key   = v.key;
    hold_len  = v.hold;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < v.exp_busy + 3; k++) begin
      #1;
      if (busy) bcnt++;
      if (done) dcnt++;
      ec = exp_con(k, h) ? v.exp_col : 4'b1111;
      if (col !== ec) cbad++;
      if (k == 16) begin
        chk($sformatf("v%0d held contact", idx), contact, 1);
        chk($sformatf("v%0d held col", idx), col, v.exp_col);
      end
      if (k == 16 + h)
        chk($sformatf("v%0d release", idx), contact, 0);
      @(negedge clk);
    end
    chk($sformatf("v%0d busy len", idx), bcnt, v.exp_busy);
    chk($sformatf("v%0d done cnt", idx), dcnt, 1);
    chk($sformatf("v%0d col trace", idx), cbad, 0);
  endtask

  initial begin
    int bcnt;
    int dcnt;
    int cbad;
    int conbad;
    logic [3:0] ec;
    logic ecn;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    line      = 4'b0000;
    req_valid = 1'b0;
    req_key   = 4'h0;
    hold_len  = 16'd0;

    vt[0] = '{4'h0, 16'd0, 4'b0000, 4'b1110, 41};
    vt[1] = '{4'h6, 16'd3, 4'b1101, 4'b1011, 43};
    vt[2] = '{4'h6, 16'd3, 4'b1011, 4'b1111, 43};
    vt[3] = '{4'hF, 16'd5, 4'b0111, 4'b0111, 45};
    vt[4] = '{4'hF, 16'd5, 4'b0000, 4'b0111, 45};
    vt[5] = '{4'h9, 16'd2, 4'b1010, 4'b1101, 42};
    vt[6] = '{4'h9, 16'd2, 4'b1111, 4'b1111, 42};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst col", col, 4'b1111);
    chk("rst ready", req_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst contact", contact, 0);
    rst = 1'b0;
    @(negedge clk);

    // Key 6, hold 100, scanning rows; second request mid-HELD
    chk("pre ready", req_ready, 1);
    req_key   = 4'h6;
    hold_len  = 16'd100;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    bcnt   = 0;
    dcnt   = 0;
    cbad   = 0;
    conbad = 0;
    for (int k = 0; k < 146; k++) begin
      line = ~(4'b0001 << (k % 4));
      if (k == 50) begin
        chk("held ready", req_ready, 0);
        req_key   = 4'hF;
        hold_len  = 16'd5;
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      ecn = exp_con(k, 100);
      ec  = (ecn && !line[1]) ? 4'b1011 : 4'b1111;
      if (contact !== ecn) conbad++;
      if (col !== ec) cbad++;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        chk("done at", k, 140);
      end
      if (k == 139) chk("busy last", busy, 1);
      if (k == 140) chk("busy end", busy, 0);
      @(negedge clk);
    end
    chk("press busy len", bcnt, 140);
    chk("press done cnt", dcnt, 1);
    chk("press contact", conbad, 0);
    chk("press col", cbad, 0);
    chk("idle after", busy, 0);

    // Table of keys, hold lengths and row drives
    foreach (vt[i]) press(vt[i], i);

    // Reset mid-HELD, request with rst high
    line      = 4'b0000;
    req_key   = 4'h0;
    hold_len  = 16'd100;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid col", col, 4'b1110);
    rst = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    chk("mrst col", col, 4'b1111);
    chk("mrst ready", req_ready, 1);
    chk("mrst busy", busy, 0);
    chk("mrst contact", contact, 0);
    chk("mrst done", done, 0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    dcnt = 0;
    bcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    chk("post rst done", dcnt, 0);
    chk("rst req ignored", bcnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
